// File: rtl/dma_seq_pkg.sv
// Shared definitions for the DMA chunk sequencer: DMA block register map,
// transfer direction, error codes and sequencer states.
package dma_seq_pkg;

    // Register byte offsets inside the DMA controller block
    localparam logic [7:0] DMA_CTRL    = 8'h00;
    localparam logic [7:0] DMA_STAT    = 8'h04;
    localparam logic [7:0] DMA_CSTART  = 8'h08;
    localparam logic [7:0] DMA_HSTARTL = 8'h0C;
    localparam logic [7:0] DMA_HSTARTH = 8'h10;
    localparam logic [7:0] DMA_LEN     = 8'h14;
    localparam logic [7:0] DMA_NEXTL   = 8'h18;
    localparam logic [7:0] DMA_NEXTH   = 8'h1C;
    localparam logic [7:0] DMA_ATTRIB  = 8'h20;

    // Value written to DMA_STAT to clear the completion status
    localparam logic [31:0] STAT_CLR_DONE = 32'h0000_0004;

    typedef enum logic {
        RD = 1'b0,   // device -> host
        WR = 1'b1    // host -> device
    } dma_dir_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_LEN     = 2'd1,
        ERR_BUS     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROG,
        S_WAIT_DONE,
        S_CLEAR,
        S_FINISH,
        S_ERROR
    } state_t;

endpackage

// File: rtl/dma_reg_writer.sv
// Single-outstanding register write master. A start pulse while idle launches
// one write; stb/adr/dat stay stable until the slave answers with ack or err.
// An err response always wins over a simultaneous ack.
module dma_reg_writer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        reg_stb_o,
    output logic [7:0]  reg_adr_o,
    output logic [31:0] reg_dat_o,
    input  logic        reg_ack_i,
    input  logic        reg_err_i
);

    logic        r_stb;
    logic [7:0]  r_adr;
    logic [31:0] r_dat;

    // Launch a write on start, hold it until the slave responds
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stb <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else if (r_stb) begin
            if (reg_ack_i || reg_err_i)
                r_stb <= 1'b0;
        end else if (start_i) begin
            r_stb <= 1'b1;
            r_adr <= adr_i;
            r_dat <= dat_i;
        end
    end

    assign busy_o    = r_stb;
    assign done_o    = r_stb & reg_ack_i & ~reg_err_i;
    assign err_o     = r_stb & reg_err_i;
    assign reg_stb_o = r_stb;
    assign reg_adr_o = r_adr;
    assign reg_dat_o = r_dat;

endmodule

// File: rtl/dma_chunk_sequencer.sv
// Splits one DMA request into chunks of at most g_MAX_CHUNK bytes, programs the
// DMA controller for each chunk, waits for its completion level and clears the
// status before moving on. Reports done, or a sticky error with a code.
module dma_chunk_sequencer
    import dma_seq_pkg::*;
#(
    parameter int unsigned g_MAX_CHUNK = 4096,
    parameter int unsigned g_TIMEOUT   = 125000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [63:0] cmd_host_i,
    input  logic [31:0] cmd_dev_i,
    input  logic [31:0] cmd_len_i,
    input  logic        cmd_dir_i,
    output logic        reg_stb_o,
    output logic [7:0]  reg_adr_o,
    output logic [31:0] reg_dat_o,
    input  logic        reg_ack_i,
    input  logic        reg_err_i,
    input  logic        dma_done_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [1:0]  err_code_o
);

    localparam logic [31:0] MAX_CHUNK  = 32'(g_MAX_CHUNK);
    localparam logic [31:0] TIMEOUT_M1 = 32'(g_TIMEOUT - 1);

    state_t      r_state, w_next;
    err_code_t   w_err_next, r_err_code;
    dma_dir_t    r_dir;
    logic [63:0] r_host;
    logic [31:0] r_dev, r_remain, r_cnt;
    logic [2:0]  r_idx;
    logic        r_error;

    logic        w_accept, w_wr_start, w_wr_busy, w_wr_done, w_wr_err;
    logic [7:0]  w_adr;
    logic [31:0] w_dat, w_chunk;

    assign w_accept   = cmd_valid_i && (r_state == S_IDLE);
    assign w_chunk    = (r_remain > MAX_CHUNK) ? MAX_CHUNK : r_remain;
    assign w_wr_start = ((r_state == S_PROG) || (r_state == S_CLEAR)) && !w_wr_busy;

    // Register/data for the current write: programming sequence or status clear
    always_comb begin
        w_adr = DMA_STAT;
        w_dat = STAT_CLR_DONE;
        if (r_state == S_PROG) begin
            case (r_idx)
                3'd0:    begin w_adr = DMA_CSTART;  w_dat = r_dev;              end
                3'd1:    begin w_adr = DMA_HSTARTL; w_dat = r_host[31:0];       end
                3'd2:    begin w_adr = DMA_HSTARTH; w_dat = r_host[63:32];      end
                3'd3:    begin w_adr = DMA_LEN;     w_dat = w_chunk;            end
                3'd4:    begin w_adr = DMA_NEXTL;   w_dat = '0;                 end
                3'd5:    begin w_adr = DMA_NEXTH;   w_dat = '0;                 end
                3'd6:    begin w_adr = DMA_ATTRIB;  w_dat = {31'b0, r_dir};     end
                default: begin w_adr = DMA_CTRL;    w_dat = 32'h0000_0001;      end
            endcase
        end
    end

    dma_reg_writer u_writer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (w_wr_start),
        .adr_i     (w_adr),
        .dat_i     (w_dat),
        .busy_o    (w_wr_busy),
        .done_o    (w_wr_done),
        .err_o     (w_wr_err),
        .reg_stb_o (reg_stb_o),
        .reg_adr_o (reg_adr_o),
        .reg_dat_o (reg_dat_o),
        .reg_ack_i (reg_ack_i),
        .reg_err_i (reg_err_i)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state, error reason and status outputs
    always_comb begin
        w_next      = r_state;
        w_err_next  = ERR_NONE;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) begin
                    if (cmd_len_i[1:0] != 2'b00) begin
                        w_next     = S_ERROR;
                        w_err_next = ERR_LEN;
                    end else if (cmd_len_i == '0) begin
                        w_next = S_FINISH;
                    end else begin
                        w_next = S_PROG;
                    end
                end
            end
            S_PROG: begin
                if (w_wr_err) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_BUS;
                end else if (w_wr_done && r_idx == 3'd7) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (dma_done_i) begin
                    w_next = S_CLEAR;
                end else if (r_cnt == TIMEOUT_M1) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_TIMEOUT;
                end
            end
            S_CLEAR: begin
                if (w_wr_err) begin
                    w_next     = S_ERROR;
                    w_err_next = ERR_BUS;
                end else if (w_wr_done) begin
                    w_next = (r_remain == w_chunk) ? S_FINISH : S_PROG;
                end
            end
            S_FINISH: begin
                done_o = 1'b1;
                w_next = S_IDLE;
            end
            S_ERROR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Transfer bookkeeping: addresses, remaining length, write index, timeout counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_host   <= '0;
            r_dev    <= '0;
            r_remain <= '0;
            r_dir    <= RD;
            r_idx    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_host   <= cmd_host_i;
                    r_dev    <= cmd_dev_i;
                    r_remain <= cmd_len_i;
                    r_dir    <= dma_dir_t'(cmd_dir_i);
                    r_idx    <= '0;
                end
                S_PROG: begin
                    r_cnt <= '0;
                    if (w_wr_done) r_idx <= r_idx + 3'd1;
                end
                S_WAIT_DONE: r_cnt <= r_cnt + 32'd1;
                S_CLEAR: if (w_wr_done) begin
                    r_host   <= r_host + 64'(w_chunk);
                    r_dev    <= r_dev + w_chunk;
                    r_remain <= r_remain - w_chunk;
                end
                default: ;
            endcase
        end
    end

    // Sticky error flag and code; a newly accepted command clears them
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (w_next == S_ERROR && r_state != S_ERROR) begin
            r_error    <= 1'b1;
            r_err_code <= w_err_next;
        end else if (w_accept) begin
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end
    end

    assign error_o    = r_error;
    assign err_code_o = r_err_code;

endmodule

// File: tb/tb_dma_chunk_sequencer.sv
// Randomised scoreboard bench for dma_chunk_sequencer with a responding
// register slave and DMA completion model.
module tb_dma_chunk_sequencer;

    localparam int MAXC = 4096;
    localparam int TMO  = 300;

    typedef struct packed {
        logic [7:0]  adr;
        logic [31:0] dat;
    } wr_t;

    logic        clk = 0, rst = 1;
    logic        cmd_valid = 0, cmd_ready, cmd_dir = 0;
    logic [63:0] cmd_host = 0;
    logic [31:0] cmd_dev = 0, cmd_len = 0;
    logic        reg_stb, reg_ack, reg_err, dma_done;
    logic [7:0]  reg_adr;
    logic [31:0] reg_dat;
    logic        busy, done, error;
    logic [1:0]  err_code;

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, mon_wr = 0, stb_cyc = 0, t_start = 0;
    int g_err_at = -1, sl_idx = 0, wait_cnt = 0, done_dly = -1;
    bit g_no_done = 0;
    wr_t exp_q[$];

    dma_chunk_sequencer #(.g_MAX_CHUNK(MAXC), .g_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_host_i(cmd_host), .cmd_dev_i(cmd_dev), .cmd_len_i(cmd_len), .cmd_dir_i(cmd_dir),
        .reg_stb_o(reg_stb), .reg_adr_o(reg_adr), .reg_dat_o(reg_dat),
        .reg_ack_i(reg_ack), .reg_err_i(reg_err), .dma_done_i(dma_done),
        .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Register slave + DMA engine: random ack latency, optional injected error,
    // completion level raised a random delay after the start write, dropped by the clear write.
    initial begin
        reg_ack = 0; reg_err = 0; dma_done = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                reg_ack = 0; reg_err = 0; dma_done = 0; done_dly = -1; wait_cnt = 0;
            end else begin
                if (reg_ack || reg_err) begin
                    reg_ack = 0; reg_err = 0;
                end else if (reg_stb) begin
                    if (wait_cnt > 0) wait_cnt--;
                    else begin
                        if (sl_idx == g_err_at) begin
                            reg_err = 1; reg_ack = 1'($urandom_range(0, 1));
                        end else begin
                            reg_ack = 1;
                            if (reg_adr == 8'h00 && !g_no_done) done_dly = $urandom_range(0, 6);
                            if (reg_adr == 8'h04) dma_done = 0;
                        end
                        sl_idx++;
                        wait_cnt = $urandom_range(0, 2);
                    end
                end
                if (done_dly == 0) begin dma_done = 1; done_dly = -1; end
                else if (done_dly > 0) done_dly--;
            end
        end
    end

    // Monitor: every completed register write is popped from the scoreboard
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (reg_stb) stb_cyc++;
                if (reg_stb && (reg_ack || reg_err)) begin
                    mon_wr++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: adr 0x%0h dat 0x%0h, none expected", reg_adr, reg_dat);
                    end else begin
                        e = exp_q.pop_front();
                        if (reg_adr !== e.adr || reg_dat !== e.dat) begin
                            errors++;
                            $display("FAIL write: got adr 0x%0h dat 0x%0h expected adr 0x%0h dat 0x%0h",
                                     reg_adr, reg_dat, e.adr, e.dat);
                        end
                    end
                    if (reg_adr == 8'h00 && reg_ack && !reg_err) t_start = cyc;
                end
                if (done) done_cnt++;
            end
        end
    end

    // Reference model: expected write stream and final error code for one command
    task automatic model(input logic [63:0] h, input logic [31:0] d, input logic [31:0] len,
                         input logic dir, input int err_at, input bit no_done,
                         output int n, output int code);
        wr_t all[$];
        longint unsigned rem, ch;
        code = 0;
        if (len % 4 != 0) begin n = 0; code = 1; return; end
        rem = len;
        while (rem > 0) begin
            ch = (rem > MAXC) ? MAXC : rem;
            all.push_back('{8'h08, d});
            all.push_back('{8'h0C, h[31:0]});
            all.push_back('{8'h10, h[63:32]});
            all.push_back('{8'h14, 32'(ch)});
            all.push_back('{8'h18, 32'h0});
            all.push_back('{8'h1C, 32'h0});
            all.push_back('{8'h20, {31'b0, dir}});
            all.push_back('{8'h00, 32'h1});
            if (no_done) begin code = 3; break; end
            all.push_back('{8'h04, 32'h4});
            h = h + ch; d = d + 32'(ch); rem = rem - ch;
        end
        if (err_at >= 0 && err_at < all.size()) begin
            while (all.size() > err_at + 1) void'(all.pop_back());
            code = 2;
        end
        n = all.size();
        foreach (all[i]) exp_q.push_back(all[i]);
    endtask

    task automatic issue(input logic [63:0] h, input logic [31:0] d, input logic [31:0] len, input logic dir);
        @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1; cmd_host = h; cmd_dev = d; cmd_len = len; cmd_dir = dir;
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic run_cmd(input string nm, input logic [63:0] h, input logic [31:0] d,
                           input logic [31:0] len, input logic dir, input int err_at, input bit no_done);
        int n, code, done0, wr0, stb0, budget;
        bit hit;
        model(h, d, len, dir, err_at, no_done, n, code);
        g_err_at = err_at; g_no_done = no_done; sl_idx = 0;
        done0 = done_cnt; wr0 = mon_wr; stb0 = stb_cyc;
        budget = TMO + (len / MAXC + 2) * 120;
        issue(h, d, len, dir);
        hit = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt != done0 || error) begin hit = 1; break; end
        end
        chk({nm, "_finished"}, hit, 1);
        if (code == 3) chk({nm, "_timeout_cycles"}, cyc - t_start, TMO + 1);
        repeat (4) @(negedge clk);
        chk({nm, "_err_code"}, err_code, code);
        chk({nm, "_error"}, error, code != 0);
        chk({nm, "_done_pulses"}, done_cnt - done0, code == 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_ready"}, cmd_ready, 1);
        chk({nm, "_stb_idle"}, reg_stb, 0);
        chk({nm, "_writes"}, mon_wr - wr0, n);
        chk({nm, "_left"}, exp_q.size(), 0);
        if (n == 0) chk({nm, "_stb_cycles"}, stb_cyc - stb0, 0);
        exp_q.delete();
        g_err_at = -1; g_no_done = 0;
    endtask

    initial begin
        int n, code, k;
        logic [31:0] len;
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cmd_ready, 1);   chk("rst_stb", reg_stb, 0);
        chk("rst_adr", reg_adr, 0);       chk("rst_dat", reg_dat, 0);
        chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
        chk("rst_error", error, 0);       chk("rst_code", err_code, 0);
        rst = 0;

        run_cmd("single", 64'h2000_0000, 32'h100, 256, 1, -1, 0);
        run_cmd("three_chunks", 64'h1234_5678_0000_0000, 32'h0001_0000, 10000, 0, -1, 0);
        run_cmd("bad_len", 64'h0, 32'h0, 6, 1, -1, 0);
        run_cmd("zero_len", 64'h0, 32'h0, 0, 0, -1, 0);
        run_cmd("timeout", 64'h4000, 32'h8000, 512, 1, -1, 1);
        run_cmd("bus_err", 64'h5000, 32'h9000, 1024, 0, 2, 0);
        run_cmd("after_err", 64'h6000, 32'hA000, 1024, 1, -1, 0);
        run_cmd("host_wrap", 64'hFFFF_FFFF_FFFF_F000, 32'hFFFF_F000, 8192, 1, -1, 0);

        // Reset during chunk 2, then a fresh command from its own addresses
        model(64'h7000_0000, 32'h200, 8192, 0, -1, 0, n, code);
        g_err_at = -1; g_no_done = 0; sl_idx = 0;
        k = mon_wr;
        issue(64'h7000_0000, 32'h200, 8192, 0);
        for (int i = 0; i < 400 && mon_wr - k < 11; i++) @(negedge clk);
        chk("mid_chunk2_reached", mon_wr - k >= 11, 1);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        chk("arst_ready", cmd_ready, 1);  chk("arst_stb", reg_stb, 0);
        chk("arst_adr", reg_adr, 0);      chk("arst_dat", reg_dat, 0);
        chk("arst_busy", busy, 0);        chk("arst_done", done, 0);
        chk("arst_error", error, 0);      chk("arst_code", err_code, 0);
        @(negedge clk); rst = 0;
        exp_q.delete();
        run_cmd("post_reset", 64'h0000_00AB_0000_1000, 32'h3000, 4100, 1, -1, 0);

        // Random commands
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 7))
                0:       len = 0;
                1:       len = 4 * $urandom_range(0, 3000) + $urandom_range(1, 3);
                default: len = 4 * $urandom_range(1, 3500);
            endcase
            run_cmd("rand", {$urandom, $urandom}, $urandom, len, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
